// File: rtl/ifetch_unit.sv
// Instruction fetch unit: single-outstanding icache fetch, static/BHT next-PC
// prediction, circular instruction queue and a one-entry-per-cycle issue port.
module ifetch_unit #(
    parameter int          QUEUE_DEPTH    = 16,
    parameter int          BHT_BITS       = 8,
    parameter int          ENABLE_PREDICT = 1,
    parameter logic [31:0] RESET_PC       = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        icache_valid,
    input  logic [31:0] icache_inst,
    output logic        icache_enable,
    output logic [31:0] pc_to_icache,
    input  logic        rob_full,
    input  logic        rs_full,
    input  logic        lsb_full,
    output logic        issue_enable,
    output logic [31:0] inst_to_issue,
    output logic [31:0] pc_to_issue,
    output logic        predict_to_issue,
    input  logic        rob_jump_flag,
    input  logic [31:0] rob_target_pc,
    input  logic        rob_predict_flag,
    input  logic        rob_branch_result,
    input  logic [31:0] rob_branch_pc
);

    localparam int QW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int BHT_ENTRIES = 1 << BHT_BITS;
    localparam logic [QW:0] FULL_COUNT = (QW + 1)'(QUEUE_DEPTH);
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    state_t      state_reg;
    state_t      state_next;
    logic [31:0] fetch_pc_reg;
    logic [31:0] fetch_pc_next;

    logic [QW-1:0] head_reg;
    logic [QW-1:0] tail_reg;
    logic [QW:0]   count_reg;

    logic [31:0] q_inst_mem [QUEUE_DEPTH];
    logic [31:0] q_pc_mem   [QUEUE_DEPTH];
    logic        q_pred_mem [QUEUE_DEPTH];

    logic [BHT_ENTRIES-1:0] bht_msb;
    logic [BHT_BITS-1:0]    bht_idx;
    logic [BHT_BITS-1:0]    upd_idx;

    logic        redirect;
    logic        push;
    logic        pop;
    logic        predict_taken;
    logic [31:0] j_imm;
    logic [31:0] b_imm;
    logic [31:0] next_pc;
    logic        next_pred;
    logic        unused_pc_bits;

    assign redirect = rob_jump_flag;
    assign push     = (state_reg == FETCH) && icache_valid && !redirect;
    assign pop      = (count_reg != '0) && !rob_full && !rs_full && !lsb_full && !redirect;

    assign icache_enable = (state_reg == FETCH);
    assign pc_to_icache  = fetch_pc_reg;

    assign bht_idx = fetch_pc_reg[BHT_BITS+1:2];
    assign upd_idx = rob_branch_pc[BHT_BITS+1:2];
    assign unused_pc_bits = ^{rob_branch_pc[31:BHT_BITS+2], rob_branch_pc[1:0]};

    // Next-PC decode of the instruction arriving this cycle; the BHT lookup
    // sees the counter value from before any same-cycle update.
    always_comb begin
        j_imm = {{11{icache_inst[31]}}, icache_inst[31], icache_inst[19:12],
                 icache_inst[20], icache_inst[30:21], 1'b0};
        b_imm = {{19{icache_inst[31]}}, icache_inst[31], icache_inst[7],
                 icache_inst[30:25], icache_inst[11:8], 1'b0};
        predict_taken = (ENABLE_PREDICT != 0) && bht_msb[bht_idx];
        next_pc   = fetch_pc_reg + 32'd4;
        next_pred = 1'b0;
        case (icache_inst[6:0])
            OP_JAL: begin
                next_pc   = fetch_pc_reg + j_imm;
                next_pred = 1'b1;
            end
            OP_BRANCH: begin
                if (predict_taken) begin
                    next_pc   = fetch_pc_reg + b_imm;
                    next_pred = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_next    = state_reg;
        fetch_pc_next = fetch_pc_reg;
        case (state_reg)
            IDLE: begin
                if (!redirect && (count_reg < FULL_COUNT)) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                if (icache_valid) begin
                    state_next = IDLE;
                end
                if (push) begin
                    fetch_pc_next = next_pc;
                end
            end
            default: state_next = IDLE;
        endcase
        if (redirect) begin
            state_next    = IDLE;
            fetch_pc_next = rob_target_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            fetch_pc_reg <= RESET_PC;
        end else if (rdy) begin
            state_reg    <= state_next;
            fetch_pc_reg <= fetch_pc_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else if (rdy) begin
            if (redirect) begin
                head_reg  <= '0;
                tail_reg  <= '0;
                count_reg <= '0;
            end else begin
                if (push) begin
                    tail_reg <= tail_reg + 1'b1;
                end
                if (pop) begin
                    head_reg <= head_reg + 1'b1;
                end
                case ({push, pop})
                    2'b10:   count_reg <= count_reg + 1'b1;
                    2'b01:   count_reg <= count_reg - 1'b1;
                    default: ;
                endcase
            end
        end
    end

    // Queue storage carries no reset; occupancy is tracked by count_reg alone.
    always_ff @(posedge clk) begin
        if (!rst && rdy && push) begin
            q_inst_mem[tail_reg] <= icache_inst;
            q_pc_mem[tail_reg]   <= fetch_pc_reg;
            q_pred_mem[tail_reg] <= next_pred;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            issue_enable     <= 1'b0;
            inst_to_issue    <= '0;
            pc_to_issue      <= '0;
            predict_to_issue <= 1'b0;
        end else if (rdy && pop) begin
            issue_enable     <= 1'b1;
            inst_to_issue    <= q_inst_mem[head_reg];
            pc_to_issue      <= q_pc_mem[head_reg];
            predict_to_issue <= q_pred_mem[head_reg];
        end else begin
            issue_enable <= 1'b0;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < BHT_ENTRIES; gi++) begin : g_bht
            logic [1:0] ctr_reg;
            always_ff @(posedge clk) begin
                if (rst) begin
                    ctr_reg <= 2'b01;
                end else if (rdy && rob_predict_flag && (upd_idx == BHT_BITS'(gi))) begin
                    if (rob_branch_result) begin
                        if (ctr_reg != 2'b11) begin
                            ctr_reg <= ctr_reg + 2'd1;
                        end
                    end else begin
                        if (ctr_reg != 2'b00) begin
                            ctr_reg <= ctr_reg - 2'd1;
                        end
                    end
                end
            end
            assign bht_msb[gi] = ctr_reg[1];
        end
    endgenerate

endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 SHALL have parameter QUEUE_DEPTH, default 16, instruction-queue entries (power of 2, >=2).
REQ-002 SHALL have parameter BHT_BITS, default 8, branch-history-table index width (2^BHT_BITS 2-bit counters).
REQ-003 SHALL have parameter ENABLE_PREDICT, default 1, 1 = use BHT for branch direction, 0 = always predict not-taken.
REQ-004 SHALL have parameter RESET_PC, default 32'h0, fetch PC after reset.
REQ-005 SHALL use one clock and a synchronous, active-high reset, with ports clk and rst.
REQ-006 Ports:
- clk  in  1  clock
- rst  in  1  sync active-high reset
- rdy  in  1  global ready; 0 = pause
- icache_valid  in  1  icache_inst valid this cycle
- icache_inst  in  32  fetched instruction
- icache_enable  out  1  fetch request
- pc_to_icache  out  32  fetch address
- rob_full, rs_full, lsb_full  in  1 each  downstream stall sources
- issue_enable  out  1  one-cycle issue strobe
- inst_to_issue  out  32  issued instruction
- pc_to_issue  out  32  issued PC
- predict_to_issue  out  1  predicted-taken flag of issued inst
- rob_jump_flag  in  1  redirect (mispredict/jalr)
- rob_target_pc  in  32  redirect target
- rob_predict_flag  in  1  BHT update strobe
- rob_branch_result  in  1  actual outcome, 1 = taken
- rob_branch_pc  in  32  PC of resolved branch

Function
REQ-007 Fetch FSM SHALL have states IDLE and FETCH; IDLE->FETCH when queue count < QUEUE_DEPTH and no redirect; FETCH->IDLE on icache_valid or redirect.
REQ-008 icache_enable SHALL be 1 and pc_to_icache SHALL equal fetch PC exactly while state==FETCH; at most one fetch outstanding.
REQ-009 On icache_valid in FETCH, SHALL push {inst, pc, pred} into queue and load fetch PC with next PC at same edge.
REQ-010 Next PC: opcode 1101111 (JAL) -> pc+J-imm, pred=1; opcode 1100011 (branch) -> pc+B-imm with pred=1 if ENABLE_PREDICT and BHT[pc[BHT_BITS+1:2]][1]==1, else pc+4, pred=0; all others incl. JALR -> pc+4, pred=0.
REQ-011 Immediates SHALL be sign-extended to 32 bits; PC arithmetic modulo 2^32.
REQ-012 Queue SHALL be circular, head/tail wrap at QUEUE_DEPTH, count 0..QUEUE_DEPTH; push never occurs when full (guaranteed by REQ-007).
REQ-013 Pop SHALL occur when count>0, rob_full=rs_full=lsb_full=0, no redirect; issue_enable<=1 and outputs<=head entry at that edge, else issue_enable<=0 and other outputs hold.
REQ-014 Push and pop in same cycle SHALL leave count unchanged.
REQ-015 Latency: icache_valid at edge N, empty queue, no stall -> issue_enable high after edge N+1.
REQ-016 Redirect (rob_jump_flag=1) SHALL at that edge: clear queue, fetch PC<=rob_target_pc, state<=IDLE, issue_enable<=0; a same-cycle icache_valid SHALL be discarded.
REQ-017 icache_valid while IDLE SHALL be ignored.
REQ-018 On rob_predict_flag, BHT[rob_branch_pc[BHT_BITS+1:2]] SHALL saturating-increment if rob_branch_result=1, else saturating-decrement; update proceeds regardless of redirect.
REQ-019 Same-cycle BHT update and lookup of same index SHALL use pre-update value.
REQ-020 When rdy=0, all state SHALL hold except issue_enable, which SHALL be cleared to 0.

Reset
REQ-021 rst=1 SHALL set fetch PC=RESET_PC, state=IDLE, queue empty, issue_enable=0, inst_to_issue=0, pc_to_issue=0, predict_to_issue=0, all BHT counters=2'b01; rst overrides rdy and redirect.
REQ-022 Reset asserted mid-FETCH SHALL drop the in-flight fetch; icache_enable=0 the cycle after.

Verification
REQ-023 Reset, icache returns 32'h00000013 at 0,4,8 -> issue pc_to_issue 0,4,8 in order, predict_to_issue=0.
REQ-024 JAL 32'h0080006F at pc 0x10 -> next pc_to_icache 0x18, predict_to_issue=1.
REQ-025 Branch 32'hFE000EE3 (beq, -4) at 0x20 after two taken updates for pc 0x20 -> next fetch 0x1C, pred=1; with ENABLE_PREDICT=0 -> 0x24, pred=0.
REQ-026 rob_full=1, QUEUE_DEPTH=4 -> exactly 4 pushes then icache_enable stays 0; release -> 4 strobes in consecutive cycles.
REQ-027 rob_jump_flag with target 0x100 coinciding with icache_valid -> queue empty, that inst never issued, next pc_to_icache=0x100.
REQ-028 rdy=0 for 3 cycles mid-stream -> no issue_enable, no PC/queue change; resumes with next entry.
